// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Pipeline hazard controller for the RV32 5-stage core. Sits beside the ID
// stage and drives the PC, IF/ID and ID/EX control signals.
//
//   * Load-use hazards stall the front end for LOAD_LAT cycles.
//   * Branch-operand hazards (operand produced in EX, or loaded in MEM)
//     stall for one cycle.
//   * A taken branch without a hazard flushes IF/ID for FLUSH_SLOTS cycles.
//   * mem_busy freezes the whole front end and holds the state machine.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined     -> saturating stall/flush/freeze performance counters
//   not defined -> the counter ports are tied to zero, no counter registers
//
// Parameters:
//   REG_AW       register-address width
//   LOAD_LAT     load-use stall cycles (1..7)
//   FLUSH_SLOTS  IF_Flush cycles per taken branch (1..3)
//   CNT_W        performance-counter width
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   memRead_IDEX               load in EX
//   regWrite_IDEX, rd_IDEX     EX instruction writes rd / EX destination
//   memRead_EXMEM, rd_EXMEM    load in MEM / MEM destination
//   rs1_IFID, rs2_IFID         ID source registers
//   use_rs1, use_rs2           ID instruction actually reads rs1 / rs2
//   branch, branch_taken       branch in ID / resolved taken
//   mem_busy                   data memory not ready
//   stall, PCWrite, IFIDWrite,
//   IDEX_Bubble, IF_Flush      pipeline control outputs (combinational)
//   stall_cnt, flush_cnt,
//   freeze_cnt                 performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_SLOTS = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead_IDEX,
    input  logic              regWrite_IDEX,
    input  logic [REG_AW-1:0] rd_IDEX,
    input  logic              memRead_EXMEM,
    input  logic [REG_AW-1:0] rd_EXMEM,
    input  logic [REG_AW-1:0] rs1_IFID,
    input  logic [REG_AW-1:0] rs2_IFID,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic              branch,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              stall,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IDEX_Bubble,
    output logic              IF_Flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  freeze_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LU_STALL,
        FLUSH
    } state_t;

    // Reload values: the cycle that enters a state is already the first slot.
    localparam logic [2:0] LU_INIT    = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_SLOTS - 1);

    state_t     state;
    logic [2:0] cnt;

    logic match_ex;
    logic match_mem;
    logic lu_hit;
    logic br_hit;

    // x0 never carries a real dependency, and unused source fields are
    // ignored so that immediates aliasing a register number do not stall.
    assign match_ex  = (rd_IDEX != '0) &&
                       ((use_rs1 && (rs1_IFID == rd_IDEX)) ||
                        (use_rs2 && (rs2_IFID == rd_IDEX)));
    assign match_mem = (rd_EXMEM != '0) &&
                       ((use_rs1 && (rs1_IFID == rd_EXMEM)) ||
                        (use_rs2 && (rs2_IFID == rd_EXMEM)));

    assign lu_hit = memRead_IDEX && match_ex;
    assign br_hit = branch && ((regWrite_IDEX && match_ex) ||
                               (memRead_EXMEM && match_mem));

    // Output decode. Reset forces idle values immediately, then a busy data
    // memory overrides everything with a freeze; otherwise the current state
    // and the hazard detectors decide. A taken branch that coincides with a
    // hazard is dropped because it re-resolves once the operands are ready.
    always_comb begin
        stall       = 1'b0;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEX_Bubble = 1'b0;
        IF_Flush    = 1'b0;
        if (!rst_n) begin
            stall = 1'b0;
        end else if (mem_busy) begin
            stall     = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else begin
            case (state)
                LU_STALL: begin
                    stall       = 1'b1;
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEX_Bubble = 1'b1;
                end
                FLUSH: begin
                    IF_Flush = 1'b1;
                end
                default: begin
                    if (lu_hit || br_hit) begin
                        stall       = 1'b1;
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end else if (branch_taken) begin
                        IF_Flush = 1'b1;
                    end
                end
            endcase
        end
    end

    // State and slot counter. A busy memory holds both untouched so that the
    // stall or flush resumes exactly where it left off; multi-cycle states
    // are only entered when the configured length exceeds one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (!mem_busy) begin
            case (state)
                IDLE: begin
                    if (lu_hit) begin
                        if (LOAD_LAT > 1) begin
                            state <= LU_STALL;
                            cnt   <= LU_INIT;
                        end
                    end else if (!br_hit && branch_taken) begin
                        if (FLUSH_SLOTS > 1) begin
                            state <= FLUSH;
                            cnt   <= FLUSH_INIT;
                        end
                    end
                end
                LU_STALL, FLUSH: begin
                    if (cnt == 3'd1) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] freeze_q;

    // Performance counters sample the decoded outputs each cycle and stick
    // at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            flush_q  <= '0;
            freeze_q <= '0;
        end else begin
            if (IDEX_Bubble && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
            if (IF_Flush && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + 1'b1;
            end
            if (mem_busy && (freeze_q != {CNT_W{1'b1}})) begin
                freeze_q <= freeze_q + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign freeze_cnt = freeze_q;
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//
// Directed testbench for hazard_ctrl_unit built with LOAD_LAT=2 and
// FLUSH_SLOTS=2. Inputs change 1 ns after the rising edge and outputs are
// sampled on the falling edge. Counter expectations depend on whether
// HAZARD_PERF_CNT_EN is defined for the build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_ctrl_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    // Output vector order: {stall, PCWrite, IFIDWrite, IDEX_Bubble, IF_Flush}
    localparam logic [4:0] IDLE_O   = 5'b01100;
    localparam logic [4:0] STALL_O  = 5'b10010;
    localparam logic [4:0] FREEZE_O = 5'b10000;
    localparam logic [4:0] FLUSH_O  = 5'b01101;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] EXP_STALL  = 16'd4;
    localparam logic [CNT_W-1:0] EXP_FLUSH  = 16'd2;
    localparam logic [CNT_W-1:0] EXP_FREEZE = 16'd3;
`else
    localparam logic [CNT_W-1:0] EXP_STALL  = 16'd0;
    localparam logic [CNT_W-1:0] EXP_FLUSH  = 16'd0;
    localparam logic [CNT_W-1:0] EXP_FREEZE = 16'd0;
`endif

    logic              clk;
    logic              rst_n;
    logic              memRead_IDEX;
    logic              regWrite_IDEX;
    logic [REG_AW-1:0] rd_IDEX;
    logic              memRead_EXMEM;
    logic [REG_AW-1:0] rd_EXMEM;
    logic [REG_AW-1:0] rs1_IFID;
    logic [REG_AW-1:0] rs2_IFID;
    logic              use_rs1;
    logic              use_rs2;
    logic              branch;
    logic              branch_taken;
    logic              mem_busy;
    logic              stall;
    logic              PCWrite;
    logic              IFIDWrite;
    logic              IDEX_Bubble;
    logic              IF_Flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  freeze_cnt;

    logic [4:0] outs;
    int vectors = 0;
    int errors  = 0;

    assign outs = {stall, PCWrite, IFIDWrite, IDEX_Bubble, IF_Flush};

    hazard_ctrl_unit #(
        .REG_AW     (REG_AW),
        .LOAD_LAT   (2),
        .FLUSH_SLOTS(2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memRead_IDEX (memRead_IDEX),
        .regWrite_IDEX(regWrite_IDEX),
        .rd_IDEX      (rd_IDEX),
        .memRead_EXMEM(memRead_EXMEM),
        .rd_EXMEM     (rd_EXMEM),
        .rs1_IFID     (rs1_IFID),
        .rs2_IFID     (rs2_IFID),
        .use_rs1      (use_rs1),
        .use_rs2      (use_rs2),
        .branch       (branch),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .stall        (stall),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IDEX_Bubble  (IDEX_Bubble),
        .IF_Flush     (IF_Flush),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .freeze_cnt   (freeze_cnt)
    );

    // 100 MHz core clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Return every hazard-related input to its quiet value.
    task automatic clear_inputs();
        memRead_IDEX  = 1'b0;
        regWrite_IDEX = 1'b0;
        rd_IDEX       = '0;
        memRead_EXMEM = 1'b0;
        rd_EXMEM      = '0;
        rs1_IFID      = '0;
        rs2_IFID      = '0;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        branch        = 1'b0;
        branch_taken  = 1'b0;
        mem_busy      = 1'b0;
    endtask

    // Reset holds idle outputs even with mem_busy high, and clears counters.
    task automatic test_reset();
        clear_inputs();
        rst_n    = 1'b0;
        mem_busy = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL reset_outs: got %b expected %b", outs, IDLE_O);
        end
        vectors++;
        if ({stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_cnts: got %0d/%0d/%0d expected 0/0/0",
                     stall_cnt, flush_cnt, freeze_cnt);
        end
        mem_busy = 1'b0;
        rst_n    = 1'b1;
        next_cycle();
        @(negedge clk);
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got %b expected %b", outs, IDLE_O);
        end
        next_cycle();
    endtask

    // Load-use with LOAD_LAT=2: two stall cycles, second one held by state.
    task automatic test_load_use();
        clear_inputs();
        memRead_IDEX = 1'b1;
        rd_IDEX      = 5'd5;
        rs2_IFID     = 5'd5;
        use_rs2      = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== STALL_O) begin
            errors++;
            $display("[TB] FAIL lu_cycle1: got %b expected %b", outs, STALL_O);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (outs !== STALL_O) begin
            errors++;
            $display("[TB] FAIL lu_cycle2: got %b expected %b", outs, STALL_O);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL lu_done: got %b expected %b", outs, IDLE_O);
        end
        next_cycle();
    endtask

    // x0 destination and unused operands never raise a hazard.
    task automatic test_filtering();
        clear_inputs();
        memRead_IDEX = 1'b1;
        rd_IDEX      = 5'd0;
        rs2_IFID     = 5'd0;
        use_rs2      = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL filter_x0: got %b expected %b", outs, IDLE_O);
        end
        next_cycle();
        rd_IDEX  = 5'd5;
        rs2_IFID = 5'd5;
        use_rs2  = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL filter_unused: got %b expected %b", outs, IDLE_O);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL filter_after: got %b expected %b", outs, IDLE_O);
        end
        next_cycle();
    endtask

    // Branch operand hazards stall one cycle and suppress the taken flush.
    task automatic test_branch_hazard();
        clear_inputs();
        branch        = 1'b1;
        branch_taken  = 1'b1;
        rs1_IFID      = 5'd7;
        use_rs1       = 1'b1;
        memRead_EXMEM = 1'b1;
        rd_EXMEM      = 5'd7;
        @(negedge clk);
        vectors++;
        if (outs !== STALL_O) begin
            errors++;
            $display("[TB] FAIL br_mem_stall: got %b expected %b", outs, STALL_O);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL br_mem_one_cycle: got %b expected %b", outs, IDLE_O);
        end
        next_cycle();
        branch        = 1'b1;
        regWrite_IDEX = 1'b1;
        rd_IDEX       = 5'd3;
        rs2_IFID      = 5'd3;
        use_rs2       = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== STALL_O) begin
            errors++;
            $display("[TB] FAIL br_ex_stall: got %b expected %b", outs, STALL_O);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL br_ex_one_cycle: got %b expected %b", outs, IDLE_O);
        end
        next_cycle();
    endtask

    // Two flush slots with a three-cycle freeze between them, then counters.
    task automatic test_flush_busy();
        clear_inputs();
        branch       = 1'b1;
        branch_taken = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== FLUSH_O) begin
            errors++;
            $display("[TB] FAIL flush_slot1: got %b expected %b", outs, FLUSH_O);
        end
        next_cycle();
        clear_inputs();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (outs !== FREEZE_O) begin
                errors++;
                $display("[TB] FAIL flush_freeze%0d: got %b expected %b", i, outs, FREEZE_O);
            end
            next_cycle();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs !== FLUSH_O) begin
            errors++;
            $display("[TB] FAIL flush_slot2: got %b expected %b", outs, FLUSH_O);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL flush_done: got %b expected %b", outs, IDLE_O);
        end
        vectors++;
        if (stall_cnt !== EXP_STALL) begin
            errors++;
            $display("[TB] FAIL stall_cnt: got %0d expected %0d", stall_cnt, EXP_STALL);
        end
        vectors++;
        if (flush_cnt !== EXP_FLUSH) begin
            errors++;
            $display("[TB] FAIL flush_cnt: got %0d expected %0d", flush_cnt, EXP_FLUSH);
        end
        vectors++;
        if (freeze_cnt !== EXP_FREEZE) begin
            errors++;
            $display("[TB] FAIL freeze_cnt: got %0d expected %0d", freeze_cnt, EXP_FREEZE);
        end
        next_cycle();
    endtask

    // A freeze inside LU_STALL must not consume a stall slot.
    task automatic test_stall_busy();
        clear_inputs();
        memRead_IDEX = 1'b1;
        rd_IDEX      = 5'd9;
        rs1_IFID     = 5'd9;
        use_rs1      = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== STALL_O) begin
            errors++;
            $display("[TB] FAIL lub_cycle1: got %b expected %b", outs, STALL_O);
        end
        next_cycle();
        clear_inputs();
        mem_busy = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== FREEZE_O) begin
            errors++;
            $display("[TB] FAIL lub_freeze: got %b expected %b", outs, FREEZE_O);
        end
        next_cycle();
        mem_busy = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs !== STALL_O) begin
            errors++;
            $display("[TB] FAIL lub_cycle2: got %b expected %b", outs, STALL_O);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL lub_done: got %b expected %b", outs, IDLE_O);
        end
        next_cycle();
    endtask

    // Reset asserted inside LU_STALL: immediate idle, nothing left over.
    task automatic test_reset_mid_stall();
        clear_inputs();
        memRead_IDEX = 1'b1;
        rd_IDEX      = 5'd5;
        rs2_IFID     = 5'd5;
        use_rs2      = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== STALL_O) begin
            errors++;
            $display("[TB] FAIL rst_pre_stall: got %b expected %b", outs, STALL_O);
        end
        next_cycle();
        clear_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL rst_mid_stall: got %b expected %b", outs, IDLE_O);
        end
        vectors++;
        if ({stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid_cnts: got %0d/%0d/%0d expected 0/0/0",
                     stall_cnt, flush_cnt, freeze_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        vectors++;
        if (outs !== IDLE_O) begin
            errors++;
            $display("[TB] FAIL rst_no_residual: got %b expected %b", outs, IDLE_O);
        end
        next_cycle();
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_load_use();
        test_filtering();
        test_branch_hazard();
        test_flush_busy();
        test_stall_busy();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the RV32 5-stage core, sitting beside the ID stage and driving PC, IF/ID and ID/EX control. It detects load-use and branch-operand hazards with x0 and unused-operand filtering, holds multi-cycle load-use stalls, and flushes for a programmable number of slots after a taken branch. It also freezes the whole front end while data memory is busy. A small state machine with down-counters replaces the purely combinational stall/flush decision of the previous generation.

## Interface
- REG_AW, 5, register-address width
- LOAD_LAT, 1, load-use stall cycles (1..7)
- FLUSH_SLOTS, 1, cycles IF_Flush stays high per taken branch (1..3)
- CNT_W, 16, performance-counter width
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- memRead_IDEX  in  1  load in EX
- regWrite_IDEX  in  1  EX instruction writes rd
- rd_IDEX  in  REG_AW  EX destination
- memRead_EXMEM  in  1  load in MEM
- rd_EXMEM  in  REG_AW  MEM destination
- rs1_IFID, rs2_IFID  in  REG_AW  ID sources
- use_rs1, use_rs2  in  1  ID instruction reads rs1 / rs2
- branch  in  1  branch in ID
- branch_taken  in  1  ID branch resolved taken
- mem_busy  in  1  data memory not ready
- stall  out  1  any stall or freeze active
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID update enable
- IDEX_Bubble  out  1  insert NOP into ID/EX
- IF_Flush  out  1  clear IF/ID
- stall_cnt, flush_cnt, freeze_cnt  out  CNT_W  performance counters

## Operation
- Match rules:
  - m1 = use_rs1 && rs1_IFID==r.
  - m2 = use_rs2 && rs2_IFID==r.
  - A hazard requires r!=0.
- lu_hit = memRead_IDEX && match(rd_IDEX).
- br_hit = branch && ((regWrite_IDEX && match(rd_IDEX)) || (memRead_EXMEM && match(rd_EXMEM))).
- Priority: mem_busy > LU_STALL/FLUSH state > lu_hit > br_hit > branch_taken.
- States: IDLE, LU_STALL, FLUSH.
- IDLE:
  - mem_busy: freeze. stall=1, PCWrite=0, IFIDWrite=0, IDEX_Bubble=0, IF_Flush=0.
  - lu_hit: stall=1, PCWrite=0, IFIDWrite=0, IDEX_Bubble=1. If LOAD_LAT>1, go to LU_STALL with cnt=LOAD_LAT-1.
  - br_hit (no lu_hit): same outputs as lu_hit for one cycle; stay in IDLE.
  - branch_taken with no hazard: IF_Flush=1. If FLUSH_SLOTS>1, go to FLUSH with cnt=FLUSH_SLOTS-1.
  - branch_taken together with br_hit or lu_hit is ignored; the branch re-resolves after the stall.
- LU_STALL:
  - Outputs as for lu_hit, regardless of inputs.
  - cnt decrements each non-busy cycle; at cnt==1, return to IDLE.
- FLUSH:
  - IF_Flush=1, PCWrite=1, IFIDWrite=1, no stall.
  - cnt decrements each non-busy cycle; at cnt==1, return to IDLE.
- mem_busy in any state applies freeze outputs and holds state and cnt unchanged.
- Idle outputs: stall=0, PCWrite=1, IFIDWrite=1, IDEX_Bubble=0, IF_Flush=0.

## Timing
- Detection is combinational: outputs respond in the same cycle as the inputs; state and cnt update on the rising clk edge.
- Load-use stall lasts exactly LOAD_LAT non-busy cycles; flush lasts exactly FLUSH_SLOTS non-busy cycles.
- Reset:
  - rst_n low immediately forces state=IDLE, cnt=0 and counters=0.
  - Outputs are forced to idle values while rst_n is low, including mid-stall or mid-flush.
  - Release is synchronous to the next clk edge.
- cnt is 3 bits wide.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments per cycle with IDEX_Bubble=1.
  - flush_cnt increments per cycle with IF_Flush=1.
  - freeze_cnt increments per mem_busy cycle.
  - All counters saturate at 2^CNT_W-1.
- Not defined: all three counter ports are tied to 0 and no counter registers exist.

## Test plan
- Load-use, LOAD_LAT=2, rd_IDEX=5, rs2_IFID=5, use_rs2=1 -> PCWrite=0, IDEX_Bubble=1 for exactly 2 cycles, then idle outputs.
- Same hazard with rd_IDEX=0, or with use_rs2=0 -> no stall.
- Branch with rs1=7, load in MEM with rd_EXMEM=7 -> 1-cycle stall; branch_taken asserted in that cycle -> no IF_Flush.
- branch_taken, FLUSH_SLOTS=2, mem_busy pulsed high for 3 cycles during the second slot -> IF_Flush high for 2 non-busy cycles, freeze outputs during busy; with macro on: flush_cnt=2, freeze_cnt=3.
- rst_n dropped mid LU_STALL -> outputs idle in the same cycle; after release, no residual stall.
